// File: rtl/operand_fetcher.sv
// Read-side master for the operand ROM: walks consecutive A/B word pairs from a
// base address and hands each pair to the arithmetic unit over valid/ready.
module operand_fetcher #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [ADDRESS_WIDTH-1:0] pair_count,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_ren,
  output logic                     mem_cen,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic [DATA_WIDTH-1:0]    op_a,
  output logic [DATA_WIDTH-1:0]    op_b,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_A  = 3'd1,
    READ_B  = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                     mem_en_q, mem_en_d;
  logic [DATA_WIDTH-1:0]    op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]    op_b_q, op_b_d;
  logic                     op_valid_q, op_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    mem_address_d = mem_address_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_address;
          remaining_d = pair_count;
          state_d     = (pair_count == '0) ? DONE : READ_A;
        end
      end
      READ_A: begin
        op_a_d  = mem_data;
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        state_d = READ_B;
      end
      READ_B: begin
        op_b_d  = mem_data;
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        state_d = PRESENT;
      end
      PRESENT: begin
        if (op_ready) begin
          remaining_d = remaining_q - ADDRESS_WIDTH'(1);
          state_d     = (remaining_q == ADDRESS_WIDTH'(1)) ? DONE : READ_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe; the ROM address only moves when a read is issued.
    mem_en_d = (state_d == READ_A) || (state_d == READ_B);
    if (mem_en_d) mem_address_d = addr_d;
    op_valid_d = (state_d == PRESENT);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      mem_address_q <= '0;
      mem_en_q      <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      mem_address_q <= mem_address_d;
      mem_en_q      <= mem_en_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_valid_q    <= op_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_ren     = mem_en_q;
  assign mem_cen     = mem_en_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
